// File: rtl/video_clken_gen.sv
// Multi-channel clock-enable / divided-clock generator with a settle-then-lock
// handshake; any accepted reconfiguration restarts every channel from its phase.
module video_clken_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned DEF_RATIO   = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned GATE_EN     = 1,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_ratio,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_div,
  output logic              lock
);

  localparam int unsigned SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);
  localparam logic GATE = (GATE_EN != 0);

  localparam logic ST_SETTLE = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic             state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] ratio_q [NUM_CH];
  logic [CNT_W-1:0] ratio_d [NUM_CH];
  logic [CNT_W-1:0] phase_q [NUM_CH];
  logic [CNT_W-1:0] phase_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] rm1     [NUM_CH];
  logic [CNT_W:0]   half    [NUM_CH];
  logic [NUM_CH-1:0] ce_q, ce_d, div_q, div_d;

  logic             accept, ch_ok, load;
  logic [CNT_W-1:0] new_rm1, new_phase;
  logic             gate_on;

  always_comb begin
    accept    = cfg_valid & (state_q == ST_LOCKED);
    ch_ok     = ({1'b0, cfg_ch} < NUM_CH_V);
    load      = accept & ch_ok;
    new_rm1   = (cfg_ratio == '0) ? '0 : cfg_ratio - CNT_W'(1);
    new_phase = (cfg_phase > new_rm1) ? new_rm1 : cfg_phase;
    ce_d      = '0;
    div_d     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ratio_d[i] = ratio_q[i];
      phase_d[i] = phase_q[i];
      if (load && (cfg_ch == CH_W'(i))) begin
        ratio_d[i] = cfg_ratio;
        phase_d[i] = new_phase;
      end
      rm1[i]  = (ratio_q[i] == '0) ? '0 : ratio_q[i] - CNT_W'(1);
      // ceil(r_eff/2) with r_eff = rm1 + 1
      half[i] = ({1'b0, rm1[i]} + (CNT_W + 1)'(2)) >> 1;
      if (load) begin
        cnt_d[i] = phase_d[i];
      end else begin
        cnt_d[i]  = (cnt_q[i] >= rm1[i]) ? '0 : cnt_q[i] + CNT_W'(1);
        ce_d[i]   = (cnt_q[i] == rm1[i]);
        div_d[i]  = ({1'b0, cnt_q[i]} < half[i]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    err_d    = accept & ~ch_ok;
    if (state_q == ST_SETTLE) begin
      if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
        state_d  = ST_LOCKED;
        settle_d = '0;
      end else begin
        settle_d = settle_q + SET_W'(1);
      end
    end else if (load) begin
      state_d  = ST_SETTLE;
      settle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      err_q    <= 1'b0;
      ce_q     <= '0;
      div_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ratio_q[i] <= CNT_W'(DEF_RATIO);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ce_q     <= ce_d;
      div_q    <= div_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ratio_q[i] <= ratio_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign lock      = (state_q == ST_LOCKED);
  assign cfg_ready = lock;
  assign cfg_err   = err_q;
  assign gate_on   = lock | ~GATE;
  assign ce_out    = ce_q & {NUM_CH{gate_on}};
  assign clk_div   = div_q & {NUM_CH{gate_on}};

endmodule
